// File: rtl/var_delay_line_if.sv
// Handshake/data bundle for var_delay_line: configuration and sample stream in,
// delayed sample, valid and config-error flags out.
interface var_delay_line_if #(
  parameter int DW      = 8,
  parameter int MAX_LEN = 16
);
  localparam int DLW = $clog2(MAX_LEN) + 1;

  logic           en;
  logic [DW-1:0]  in;
  logic           delay_ld;
  logic [DLW-1:0] delay;
  logic [DW-1:0]  out;
  logic           out_vld;
  logic           cfg_err;

  modport master (output en, in, delay_ld, delay, input  out, out_vld, cfg_err);
  modport slave  (input  en, in, delay_ld, delay, output out, out_vld, cfg_err);
endinterface

// File: rtl/var_delay_line.sv
// Runtime-programmable delay line on a circular buffer; out_vld marks the line as
// primed once d enabled edges have passed since reset or the last accepted load.
module var_delay_line #(
  parameter int DW      = 8,
  parameter int MAX_LEN = 16,
  parameter int DEF_LEN = 4
) (
  input logic              clk,
  input logic              rst_n,
  var_delay_line_if.slave  bus
);
  localparam int PW  = $clog2(MAX_LEN);
  localparam int DLW = PW + 1;

  typedef enum logic {FILL, RUN} state_t;

  logic [DW-1:0]  mem [MAX_LEN];
  logic [PW-1:0]  wptr_q, wptr_d, rd_addr;
  logic [DLW-1:0] cnt_q, cnt_d, delay_q, delay_d;
  logic [DW-1:0]  out_q, out_d, rd_data;
  logic           vld_q, vld_d, err_q, err_d, ld_ok;
  state_t         state_q, state_d;

  // d==1 bypasses the RAM; otherwise read the entry written d-1 enables ago
  assign rd_addr = wptr_q - PW'(delay_q - DLW'(1));
  assign rd_data = (delay_q == DLW'(1)) ? bus.in : mem[rd_addr];

  always_comb begin
    ld_ok   = bus.delay_ld && (bus.delay != '0) && (bus.delay <= DLW'(MAX_LEN));
    wptr_d  = bus.en ? wptr_q + PW'(1) : wptr_q;
    err_d   = bus.delay_ld && !ld_ok;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    out_d   = out_q;
    vld_d   = vld_q;
    state_d = state_q;
    if (ld_ok) begin
      // a load on an enabled edge still writes, but that edge is not counted
      delay_d = bus.delay;
      cnt_d   = '0;
      out_d   = '0;
      vld_d   = 1'b0;
      state_d = FILL;
    end else if (bus.en) begin
      case (state_q)
        FILL: begin
          cnt_d = cnt_q + DLW'(1);
          out_d = '0;
          if (cnt_q + DLW'(1) == delay_q) begin
            out_d   = rd_data;
            vld_d   = 1'b1;
            state_d = RUN;
          end
        end
        RUN:     out_d = rd_data;
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      cnt_q   <= '0;
      delay_q <= DLW'(DEF_LEN);
      out_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      state_q <= FILL;
    end else begin
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.en) mem[wptr_q] <= bus.in;
  end

  assign bus.out     = out_q;
  assign bus.out_vld = vld_q;
  assign bus.cfg_err = err_q;
endmodule

// File: tb/tb_var_delay_line.sv
// Randomised + directed bench for var_delay_line against a queue-based model of
// "out after edge k = input of edge k-d+1".
module tb_var_delay_line;
  localparam int DW = 8, MAX_LEN = 16, DEF_LEN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0, total_cnt = 0;

  var_delay_line_if #(.DW(DW), .MAX_LEN(MAX_LEN)) bus ();
  var_delay_line #(.DW(DW), .MAX_LEN(MAX_LEN), .DEF_LEN(DEF_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
  endtask

  // Behavioural model: history of samples since reset/accepted load.
  int        m_d, m_k;
  logic [7:0] m_hist[$];
  int        m_out, m_vld, m_err;

  initial begin
    m_d = DEF_LEN; m_k = 0; m_out = 0; m_vld = 0; m_err = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_d = DEF_LEN; m_k = 0; m_hist.delete(); m_out = 0; m_vld = 0; m_err = 0;
      end else begin
        automatic int  dl    = int'(bus.delay);
        automatic bit  legal = bus.delay_ld && dl >= 1 && dl <= MAX_LEN;
        m_err = (bus.delay_ld && !legal) ? 1 : 0;
        if (legal) begin
          m_d = dl; m_k = 0; m_hist.delete(); m_out = 0; m_vld = 0;
        end else if (bus.en) begin
          m_hist.push_back(bus.in);
          if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
          m_k++;
          if (m_k >= m_d) begin
            m_out = int'(m_hist[m_hist.size() - m_d]);
            m_vld = 1;
          end else begin
            m_out = 0; m_vld = 0;
          end
        end
      end
      #1;
      chk("model_out", int'(bus.out), m_out);
      chk("model_vld", int'(bus.out_vld), m_vld);
      chk("model_err", int'(bus.cfg_err), m_err);
    end
  end

  task automatic step(input logic e, input logic [7:0] d, input logic ld = 1'b0,
                      input logic [4:0] dl = 5'd0);
    @(negedge clk);
    bus.en = e; bus.in = d; bus.delay_ld = ld; bus.delay = dl;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.en = 1'b0; bus.delay_ld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_out", int'(bus.out), 0);
    chk("rst_vld", int'(bus.out_vld), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.en = 1'b0; bus.in = '0; bus.delay_ld = 1'b0; bus.delay = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", int'(bus.out), 0);
    chk("reset_vld", int'(bus.out_vld), 0);
    chk("reset_err", int'(bus.cfg_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Default delay 4, in = 1,2,3,...
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 8'(i));
      if (i == 3) chk("t1_vld_edge3", int'(bus.out_vld), 0);
      if (i == 4) begin
        chk("t1_vld_edge4", int'(bus.out_vld), 1);
        chk("t1_out_edge4", int'(bus.out), 1);
      end
      if (i == 7) chk("t1_out_edge7", int'(bus.out), 4);
    end

    // Delay 1 behaves as a single register
    step(1'b0, 8'h00, 1'b1, 5'd1);
    chk("t2_vld_after_ld", int'(bus.out_vld), 0);
    step(1'b1, 8'hA5);
    chk("t2_out", int'(bus.out), 'hA5);
    chk("t2_vld", int'(bus.out_vld), 1);

    // Delay MAX_LEN across the pointer wrap
    step(1'b0, 8'h00, 1'b1, 5'd16);
    for (int k = 1; k <= 41; k++) begin
      step(1'b1, 8'(k - 1));
      if (k == 15) chk("t3_vld_edge15", int'(bus.out_vld), 0);
      if (k == 16) chk("t3_out_edge16", int'(bus.out), 0);
      if (k == 41) chk("t3_out_edge41", int'(bus.out), 25);
    end

    // en toggling during fill with d=3
    step(1'b0, 8'h00, 1'b1, 5'd3);
    step(1'b1, 8'h11); step(1'b0, 8'h99); step(1'b1, 8'h22); step(1'b0, 8'h98);
    chk("t4_vld_two_en", int'(bus.out_vld), 0);
    step(1'b1, 8'h33);
    chk("t4_vld_three_en", int'(bus.out_vld), 1);
    chk("t4_out", int'(bus.out), 'h11);
    step(1'b0, 8'h44);
    chk("t4_out_frozen", int'(bus.out), 'h11);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h50 + i));

    // Illegal loads in RUN
    step(1'b1, 8'h60, 1'b1, 5'd0);
    chk("t5_err0", int'(bus.cfg_err), 1);
    chk("t5_vld0", int'(bus.out_vld), 1);
    step(1'b1, 8'h61, 1'b1, 5'd17);
    chk("t5_err17", int'(bus.cfg_err), 1);
    chk("t5_out_stream", int'(bus.out), 'h53);
    step(1'b1, 8'h62);
    chk("t5_err_clear", int'(bus.cfg_err), 0);

    // Reset mid-RUN with d=5, then refill at DEF_LEN
    step(1'b0, 8'h00, 1'b1, 5'd5);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h70 + i));
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 8'(8'h80 + i));
      if (i == 3) chk("t6_vld_edge3", int'(bus.out_vld), 0);
      if (i == 4) chk("t6_out_edge4", int'(bus.out), 'h81);
    end

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      automatic int r = int'($urandom_range(0, 99));
      if (r < 2) do_reset();
      else if (r < 8)
        step(1'($urandom_range(0, 1)), 8'($urandom), 1'b1, 5'($urandom_range(0, 20)));
      else
        step(1'($urandom_range(0, 9) < 7), 8'($urandom));
    end

    step(1'b0, 8'h00);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
